// File: rtl/framebuffer_line_fetch.sv
// rtl/framebuffer_line_fetch.sv - ping-pong line buffer fed by SDRAM bursts, drained by the display
module framebuffer_line_fetch #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BURST_LEN = 8,
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        line_req,
  input  logic        pix_rd,
  output logic [15:0] pix_data,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        late_line,
  output logic        busy
);

  localparam int IDX_W  = $clog2(H_ACTIVE + 1);
  localparam int PTR_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BURST,
    S_LINE_DONE
  } state_t;

  state_t              state;
  logic                fill_bank;
  logic                disp_bank;
  logic [LINE_W-1:0]   fetch_line;
  logic [IDX_W-1:0]    word_idx;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [PTR_W-1:0]    rd_ptr;
  logic                abort_pend;

  logic [15:0]         line_buf [2][H_ACTIVE];

  logic [PTR_W-1:0]    wr_ptr;
  logic                wr_en;
  logic [IDX_W-1:0]    word_idx_nxt;
  logic                last_beat;
  logic                line_ev;
  logic                do_restart;

  function automatic logic [23:0] line_addr(input logic [LINE_W-1:0] line,
                                            input logic [IDX_W-1:0]  idx);
    logic [47:0] a;
    a = 48'(BASE_ADDR) + 48'(line) * 48'(H_ACTIVE) + 48'(idx);
    return a[23:0];
  endfunction

  assign busy         = (state != S_IDLE);
  assign wr_ptr       = PTR_W'(word_idx) + PTR_W'(beat_cnt);
  assign wr_en        = (state == S_BURST) && rd_valid;
  assign word_idx_nxt = word_idx + IDX_W'(BURST_LEN);
  assign last_beat    = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign line_ev      = line_req && !frame_start;

  // A frame restart mid-burst is deferred until the burst's last beat lands.
  always_comb begin
    do_restart = 1'b0;
    if (state == S_BURST)
      do_restart = rd_valid && last_beat && (abort_pend || frame_start);
    else
      do_restart = frame_start;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      line_buf[fill_bank][wr_ptr] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_req     <= 1'b0;
      rd_addr    <= 24'h000000;
      pix_data   <= 16'h0000;
      late_line  <= 1'b0;
      fill_bank  <= 1'b0;
      disp_bank  <= 1'b1;
      fetch_line <= '0;
      word_idx   <= '0;
      beat_cnt   <= '0;
      rd_ptr     <= '0;
      abort_pend <= 1'b0;
    end else begin
      if (pix_rd) begin
        pix_data <= line_buf[disp_bank][rd_ptr];
        if (rd_ptr != PTR_W'(H_ACTIVE - 1))
          rd_ptr <= rd_ptr + 1'b1;
      end

      if (do_restart) begin
        state      <= S_REQ;
        rd_req     <= 1'b0;
        rd_addr    <= line_addr('0, '0);
        fill_bank  <= 1'b0;
        disp_bank  <= 1'b1;
        fetch_line <= '0;
        word_idx   <= '0;
        beat_cnt   <= '0;
        abort_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (line_ev)
              rd_ptr <= '0;
          end

          // Every entry into REQ arrives with rd_req low; it rises one cycle later.
          S_REQ: begin
            if (line_ev) begin
              late_line <= 1'b1;
              rd_ptr    <= '0;
            end
            if (!rd_req) begin
              rd_req <= 1'b1;
            end else if (rd_ack) begin
              rd_req <= 1'b0;
              state  <= S_BURST;
            end
          end

          S_BURST: begin
            if (frame_start)
              abort_pend <= 1'b1;
            if (line_ev) begin
              late_line <= 1'b1;
              rd_ptr    <= '0;
            end
            if (rd_valid) begin
              if (last_beat) begin
                beat_cnt <= '0;
                word_idx <= word_idx_nxt;
                if (word_idx_nxt == IDX_W'(H_ACTIVE)) begin
                  state <= S_LINE_DONE;
                end else begin
                  state   <= S_REQ;
                  rd_addr <= line_addr(fetch_line, word_idx_nxt);
                end
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end
          end

          S_LINE_DONE: begin
            if (line_ev) begin
              disp_bank <= fill_bank;
              fill_bank <= ~fill_bank;
              rd_ptr    <= '0;
              word_idx  <= '0;
              if (fetch_line != LINE_W'(V_ACTIVE - 1)) begin
                fetch_line <= fetch_line + 1'b1;
                rd_addr    <= line_addr(fetch_line + 1'b1, '0);
                state      <= S_REQ;
              end else begin
                state <= S_IDLE;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/framebuffer_line_fetch.md
FRAMEBUFFER_LINE_FETCH -- requirements
Module: framebuffer_line_fetch

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter H_ACTIVE, default 640: pixels per line; it SHALL be a multiple of BURST_LEN and no more than 1024.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480: lines per frame.
REQ-003 The block SHALL have parameter BURST_LEN, default 8: 16-bit words returned per SDRAM read command.
REQ-004 The block SHALL have parameter BASE_ADDR, default 24'h000000: SDRAM word address of pixel (0,0).

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have a single clock, clk (in, 1); all logic is on its rising edge.
REQ-006 The block SHALL have rst_n (in, 1): asynchronous, active-low reset.
REQ-007 The block SHALL have frame_start (in, 1): single-cycle pulse at vsync that restarts the frame.
REQ-008 The block SHALL have line_req (in, 1): single-cycle pulse at hblank start that swaps banks and starts the next fetch.
REQ-009 The block SHALL have pix_rd (in, 1): the display consumes one pixel.
REQ-010 The block SHALL have pix_data (out, 16): RGB565 pixel.
REQ-011 The block SHALL have rd_req (out, 1) and rd_addr (out, 24): SDRAM read command and word address.
REQ-012 The block SHALL have rd_ack (in, 1): command accepted by sdram_core.
REQ-013 The block SHALL have rd_valid (in, 1) and rd_data (in, 16): returned read word.
REQ-014 The block SHALL have late_line (out, 1): sticky flag; line_req arrived before the line was fully fetched.
REQ-015 The block SHALL have busy (out, 1): FSM is not in IDLE.

Function
REQ-016 Line buffer: two banks of H_ACTIVE x 16 bits (ping-pong). Registers: fill_bank, disp_bank (always each other's complement), fetch_line (0..V_ACTIVE-1), word_idx (0..H_ACTIVE), beat_cnt (0..BURST_LEN-1), rd_ptr (0..H_ACTIVE-1).
REQ-017 FSM states: IDLE, REQ, BURST, LINE_DONE.
REQ-018 REQ: assert rd_req with rd_addr = BASE_ADDR + fetch_line*H_ACTIVE + word_idx, computed mod 2^24.
REQ-019 REQ: hold rd_req and rd_addr stable until rd_ack is sampled high; that same cycle, deassert rd_req and go to BURST.
REQ-020 BURST: each rd_valid cycle writes rd_data to bank fill_bank at index word_idx+beat_cnt, then increments beat_cnt.
REQ-021 BURST: on the BURST_LEN-th beat, word_idx += BURST_LEN and beat_cnt = 0; then go to LINE_DONE if word_idx = H_ACTIVE, else to REQ.
REQ-022 rd_valid outside BURST SHALL be ignored.
REQ-023 frame_start in IDLE, REQ or LINE_DONE: next cycle fetch_line=0, word_idx=0, fill_bank=0, disp_bank=1, state REQ; rd_req drops for at least one cycle before re-assertion.
REQ-024 frame_start in BURST: set abort_pend; the burst completes with its writes; then the REQ-023 actions are applied instead of REQ-021 progress.
REQ-025 line_req in LINE_DONE: disp_bank<=fill_bank, fill_bank<=~fill_bank, rd_ptr<=0, word_idx<=0.
REQ-026 line_req in LINE_DONE with fetch_line < V_ACTIVE-1: fetch_line+1, go to REQ.
REQ-027 line_req in LINE_DONE with fetch_line = V_ACTIVE-1: go to IDLE.
REQ-028 line_req in REQ or BURST: set late_line, no bank swap, rd_ptr<=0, fetch continues unchanged.
REQ-029 line_req in IDLE: rd_ptr<=0 only.
REQ-030 frame_start and line_req in the same cycle: frame_start wins; line_req is ignored.
REQ-031 pix_rd: pix_data registered from bank disp_bank at rd_ptr, valid the cycle after pix_rd (latency 1); pix_data holds when pix_rd is low.
REQ-032 pix_rd: rd_ptr increments and saturates at H_ACTIVE-1.
REQ-033 Writes to fill_bank and reads from disp_bank in the same cycle SHALL not interfere.

Reset
REQ-034 rst_n low, at any time including mid-burst, SHALL immediately force: state IDLE; rd_req=0, rd_addr=0, pix_data=0, late_line=0, busy=0; fill_bank=0, disp_bank=1; all counters and abort_pend 0.
REQ-035 Buffer contents need not be reset.
REQ-036 After reset the block SHALL wait in IDLE for frame_start.

Verification
REQ-037 Reset then frame_start, with a memory model acking after 3 cycles -> rd_req with rd_addr=0x000000, then 0x000008, ... 0x000278; 80 bursts; LINE_DONE; late_line=0.
REQ-038 line_req after line 0 is done, then 640 pix_rd -> pix_data = words 0..639 of line 0 in order at latency 1; concurrently rd_addr starts at 0x000280 (line 1) into bank 1.
REQ-039 line_req while line 1 is mid-fetch (word_idx=320) -> late_line=1, disp_bank unchanged, fetch completes.
REQ-040 frame_start during BURST at beat 3 of 8 -> remaining 5 beats accepted, next rd_addr=0x000000, fill_bank=0.
REQ-041 Full frame: 480 line_req -> last fetch at rd_addr 0x04AD80+0x278; after the final line_req, state IDLE, busy=0.
REQ-042 rst_n pulsed low mid-burst with rd_req high -> rd_req=0 and busy=0 within the same cycle, stray rd_valid ignored.
